serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: loads two WIDTH-bit operands plus carry-in and adds LSB-first,
// one bit per clock, through a registered-carry full adder built from two half adders.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;

  logic p_bit, g_bit, pc_bit, s_bit, c_bit;
  logic last_bit;

  // Full add = half add of the operand bits, then half add with the carry.
  half_adder u_ha_ab (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .s (p_bit),
    .c (g_bit)
  );

  half_adder u_ha_c (
    .a (p_bit),
    .b (c_reg),
    .s (s_bit),
    .c (pc_bit)
  );

  assign c_bit    = g_bit | pc_bit;
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned and infers a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath register is cleared by the async reset because an
  // aborted addition must leave no stale operands, partial sum or result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            c_reg <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          s_sr  <= {s_bit, s_sr[WIDTH-1:1]};
          c_reg <= c_bit;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum_out <= {s_bit, s_sr[WIDTH-1:1]};
            cout    <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  // Pure decodes of the state register: no combinational path from any input.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and swept checks of serial_adder_ctrl at WIDTH=8.

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             cin;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum_out;

  int vectors     = 0;
  int miscompares = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Launches one addition and follows it to completion, checking latency,
  // busy duration and the return to idle; hands back the captured result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co);
    int n;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c;
    @(posedge clk); #1;
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
    n = 0;
    busy_cnt = 0;
    while (n < 40) begin
      if (busy) busy_cnt++;
      if (done) break;
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", n, 8);
    check("busy_cycles", busy_cnt, 9);
    s  = sum_out;
    co = cout;
    @(posedge clk); #1;
    check("done_after", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  logic [7:0] s_got;
  logic       c_got;
  int         pulses;
  int         last_pulse;
  bit         seen;
  logic [7:0] ra, rb;
  logic       rc;
  logic [8:0] ref_sum;

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, s_got, c_got);
    check("t1_sum", 32'(s_got), 32'h7F);
    check("t1_cout", 32'(c_got), 32'd0);

    run_op(8'hFF, 8'h01, 1'b0, s_got, c_got);
    check("t2_sum", 32'(s_got), 32'h00);
    check("t2_cout", 32'(c_got), 32'd1);

    run_op(8'hFF, 8'hFF, 1'b1, s_got, c_got);
    check("t3_sum", 32'(s_got), 32'hFF);
    check("t3_cout", 32'(c_got), 32'd1);

    // A second start while shifting must be ignored.
    @(negedge clk);
    start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        pulses++;
        check("t4_sum", 32'(sum_out), 32'h46);
        check("t4_cout", 32'(cout), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("t4_pulses", pulses, 1);
    check("t4_busy_end", 32'(busy), 32'd0);

    // Reset mid-shift: outputs clear at once and the aborted add never completes.
    @(negedge clk);
    start = 1'b1; a_in = 8'hF0; b_in = 8'h0F; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum", 32'(sum_out), 32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("t5_no_done", pulses, 0);
    run_op(8'h01, 8'h01, 1'b0, s_got, c_got);
    check("t5_sum2", 32'(s_got), 32'h02);
    check("t5_cout2", 32'(c_got), 32'd0);

    // start held high: one result every WIDTH+2 cycles, held in between.
    @(negedge clk);
    start = 1'b1; a_in = 8'h80; b_in = 8'h80; cin = 1'b0;
    pulses = 0;
    last_pulse = -1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 35; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (last_pulse >= 0) check("t6_period", cyc - last_pulse, 10);
        else                 check("t6_first", cyc, 8);
        last_pulse = cyc;
        seen = 1'b1;
      end
      if (seen) begin
        check("t6_sum", 32'(sum_out), 32'h00);
        check("t6_cout", 32'(cout), 32'd1);
      end
    end
    check("t6_pulses", pulses, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("t6_idle", 32'(busy), 32'd0);

    for (int k = 0; k < 500; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      run_op(ra, rb, rc, s_got, c_got);
      check("rand_result", 32'({c_got, s_got}), 32'(ref_sum));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
